// File: rtl/ram_copy_ctrl_pkg.sv
// Shared definitions for the ROM-to-RAM copy/verify controller.
package ram_copy_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY,
        ST_VERIFY,
        ST_LAST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ram_copy_ctrl.sv
// ROM-to-RAM copy followed by a read-back verify pass, with a host port
// that may use the RAM only while the controller is idle.
module ram_copy_ctrl
    import ram_copy_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              host_req,
    input  logic              host_wren,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ERR_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic [ADDR_W:0]     r_err_count;
    logic                r_pass;
    logic                r_done;
    logic                r_host_rvalid;
    logic                w_host_gnt;
    logic                w_cmp_en;
    logic                w_mismatch;

    // Host wins the RAM only when idle and no copy is being requested this cycle.
    assign w_host_gnt = host_req & (r_state == ST_IDLE) & ~start & ~reset;

    // Read data for idx arrives one cycle late; compare against the ROM word of the
    // delayed address, skipping the first VERIFY cycle which has no read yet.
    assign w_cmp_en   = ((r_state == ST_VERIFY) && (r_idx != '0)) || (r_state == ST_LAST);
    assign w_mismatch = (ram_q != rom_data);

    // done/pass are registered out of DONE, so busy also spans the done cycle.
    assign busy        = (r_state != ST_IDLE) | r_done;
    assign done        = r_done;
    assign pass        = r_pass;
    assign err_count   = r_err_count;
    assign host_gnt    = w_host_gnt;
    assign host_rdata  = ram_q;
    assign host_rvalid = r_host_rvalid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_COPY;
            ST_COPY:   if (r_idx == LAST_IDX) w_state_next = ST_VERIFY;
            ST_VERIFY: if (r_idx == LAST_IDX) w_state_next = ST_LAST;
            ST_LAST:   w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // RAM/ROM port drive per state, with the host steering the RAM when granted.
    always_comb begin
        rom_addr = r_idx;
        ram_addr = r_idx;
        ram_wren = 1'b0;
        ram_data = rom_data;
        case (r_state)
            ST_IDLE: begin
                if (w_host_gnt) begin
                    ram_addr = host_addr;
                    ram_wren = host_wren;
                    ram_data = host_wdata;
                end
            end
            ST_COPY:   ram_wren = 1'b1;
            ST_VERIFY: rom_addr = r_cmp_addr;
            ST_LAST:   rom_addr = r_cmp_addr;
            default:   ram_wren = 1'b0;
        endcase
        if (reset) begin
            ram_wren = 1'b0;
        end
    end

    // Index, compare address, error count, result flags and host read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_cmp_addr    <= '0;
            r_err_count   <= '0;
            r_pass        <= 1'b0;
            r_done        <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_cmp_addr    <= r_idx;
            r_done        <= (r_state == ST_DONE);
            r_host_rvalid <= w_host_gnt & ~host_wren;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                ST_COPY, ST_VERIFY: r_idx <= r_idx + IDX_ONE;
                ST_DONE: r_pass <= (r_err_count == '0);
                default: r_idx <= r_idx;
            endcase
            if (w_cmp_en && w_mismatch) begin
                r_err_count <= r_err_count + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_copy_ctrl.sv
// Scoreboard bench for ram_copy_ctrl with behavioural RAM/ROM and fault injection.
module tb_ram_copy_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 2 * DEPTH + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic          host_req = 1'b0;
    logic          host_wren = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    ram_copy_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
        .host_req(host_req), .host_wren(host_wren), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ROM and RAM; inj_mask flips bit0 of read data per address.
    logic [DW-1:0]    mem [DEPTH];
    logic [DW-1:0]    ram_q_r;
    logic [AW-1:0]    rd_addr_q;
    logic [DEPTH-1:0] inj_mask = '0;

    assign rom_data = rom_addr ^ 4'hA;
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q_r   <= mem[ram_addr];
        rd_addr_q <= ram_addr;
    end
    assign ram_q = ram_q_r ^ {{(DW-1){1'b0}}, inj_mask[rd_addr_q]};

    typedef struct { int start_cyc; int done_cyc; int errs; } op_t;
    typedef struct { int cyc; logic [DW-1:0] data; } rd_t;
    op_t opq[$];
    rd_t rdq[$];
    logic [DW-1:0] exp_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries when the DUT presents done / host_rvalid.
    initial begin : monitor
        logic exp_pass;
        op_t  op;
        rd_t  rd;
        exp_pass = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                opq.delete();
                rdq.delete();
                exp_pass = 1'b0;
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_pass", int'(pass), 0);
                chk("rst_err", int'(err_count), 0);
                chk("rst_rvalid", int'(host_rvalid), 0);
            end else begin
                if (opq.size() > 0 && cyc == opq[0].start_cyc + 1) exp_pass = 1'b0;
                chk("busy", int'(busy),
                    int'(opq.size() > 0 && cyc > opq[0].start_cyc && cyc <= opq[0].done_cyc));
                if (done) begin
                    if (opq.size() == 0) begin
                        chk("done_unexpected", 1, 0);
                    end else begin
                        op = opq.pop_front();
                        chk("done_cycle", cyc, op.done_cyc);
                        chk("err_count", int'(err_count), op.errs);
                        exp_pass = (op.errs == 0);
                    end
                end else if (opq.size() > 0 && cyc >= opq[0].done_cyc) begin
                    op = opq.pop_front();
                    chk("done_missing", 0, 1);
                end
                chk("pass", int'(pass), int'(exp_pass));
                if (host_rvalid) begin
                    if (rdq.size() == 0) begin
                        chk("rvalid_unexpected", 1, 0);
                    end else begin
                        rd = rdq.pop_front();
                        chk("rd_cycle", cyc, rd.cyc);
                        chk("rd_data", int'(host_rdata), int'(rd.data));
                    end
                end else if (rdq.size() > 0 && cyc >= rdq[0].cyc) begin
                    rd = rdq.pop_front();
                    chk("rvalid_missing", 0, 1);
                end
            end
        end
    end

    task automatic drive(input logic st, input logic rq, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        start = st; host_req = rq; host_wren = wr; host_addr = a; host_wdata = d;
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b0, 1'b1, 1'b1, a, d);
        chk("gnt_wr", int'(host_gnt), 1);
        exp_mem[a] = d;
    endtask

    task automatic host_read(input logic [AW-1:0] a);
        drive(1'b0, 1'b1, 1'b0, a, '0);
        chk("gnt_rd", int'(host_gnt), 1);
        rdq.push_back('{cyc: cyc + 1, data: exp_mem[a]});
    endtask

    task automatic begin_op(input logic [DEPTH-1:0] mask, input logic with_req);
        drive(1'b1, with_req, 1'b1, AW'($urandom), DW'($urandom));
        if (with_req) chk("gnt_vs_start", int'(host_gnt), 0);
        inj_mask = mask;
        opq.push_back('{start_cyc: cyc, done_cyc: cyc + LAT, errs: $countones(mask)});
    endtask

    task automatic busy_traffic(input int n, input logic with_starts);
        for (int k = 0; k < n; k++) begin
            drive(with_starts && ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
            if (host_req) chk("gnt_busy", int'(host_gnt), 0);
        end
    endtask

    task automatic finish_op();
        int n = 0;
        while (opq.size() > 0 && n < 3 * LAT) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            n++;
        end
        if (opq.size() > 0) chk("op_timeout", 0, 1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        inj_mask = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = DW'(i) ^ 4'hA;
        for (int i = 0; i < DEPTH; i++) chk("ram_image", int'(mem[i]), int'(exp_mem[i]));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [DEPTH-1:0] m;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("init_busy", int'(busy), 0);
        chk("init_done", int'(done), 0);
        chk("init_err", int'(err_count), 0);

        // Clean copy, then a verify with two corrupted read-backs.
        begin_op('0, 1'b0);
        finish_op();
        m = '0; m[3] = 1'b1; m[9] = 1'b1;
        begin_op(m, 1'b0);
        finish_op();

        // Host write/read while idle.
        host_write(4'd7, 4'h5);
        host_read(4'd7);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);

        // Start collides with host_req, then host requests and extra starts while busy.
        begin_op('0, 1'b1);
        busy_traffic(30, 1'b1);
        finish_op();

        // Reset at COPY idx=6 aborts with no done; a fresh run then passes.
        begin_op('0, 1'b0);
        repeat (7) drive(1'b0, 1'b0, 1'b0, '0, '0);
        host_req = 1'b1;
        reset = 1'b1;
        #1;
        chk("wren_in_reset", int'(ram_wren), 0);
        chk("gnt_in_reset", int'(host_gnt), 0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        repeat (40) drive(1'b0, 1'b0, 1'b0, '0, '0);
        begin_op('0, 1'b0);
        finish_op();

        // Randomised rounds: idle host traffic, read immediately followed by start.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) host_write(AW'($urandom), DW'($urandom));
                else host_read(AW'($urandom));
            end
            host_read(AW'($urandom));
            m = ($urandom_range(0, 2) == 0) ? '0 : DEPTH'($urandom);
            begin_op(m, $urandom_range(0, 1) == 1);
            busy_traffic(int'($urandom_range(0, 30)), 1'b1);
            finish_op();
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, '0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_copy_ctrl.md
RAM_COPY_CTRL -- requirements
Module: ram_copy_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, RAM/ROM address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 4, RAM/ROM word width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse requesting a ROM->RAM copy followed by a verify pass.
REQ-006 busy  out  1  high from the cycle after start is accepted until DONE completes.
REQ-007 done  out  1  one-cycle pulse at the end of verify.
REQ-008 pass  out  1  verify result, held until the next accepted start.
REQ-009 err_count  out  ADDR_W+1  number of mismatching words from the last verify.
REQ-010 rom_addr  out  ADDR_W; rom_data  in  DATA_W: combinational ROM port, data valid in the same cycle.
REQ-011 ram_addr  out  ADDR_W; ram_wren  out  1; ram_data  out  DATA_W; ram_q  in  DATA_W: single-port RAM with synchronous write and 1-cycle registered read.
REQ-012 host_req, host_wren  in  1; host_addr  in  ADDR_W; host_wdata  in  DATA_W: host access port.
REQ-013 host_gnt  out  1; host_rdata  out  DATA_W; host_rvalid  out  1: host grant and read return.

Function
REQ-014 States: IDLE, COPY, VERIFY, LAST, DONE; idx counter ADDR_W wide.
REQ-015 IDLE with start=1 -> COPY, idx<=0, err_count<=0, pass<=0; start takes priority over host_req in the same cycle.
REQ-016 start is ignored in every state other than IDLE.
REQ-017 COPY: rom_addr=ram_addr=idx, ram_data=rom_data, ram_wren=1; idx increments each cycle; after idx=DEPTH-1 -> VERIFY, idx<=0 (DEPTH cycles).
REQ-018 VERIFY: ram_addr=idx, ram_wren=0; a registered copy of the previous cycle's idx (cmp_addr) drives rom_addr; from the second VERIFY cycle on, ram_q != rom_data increments err_count.
REQ-019 After issuing read idx=DEPTH-1 -> LAST; LAST performs the final compare for address DEPTH-1 -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, pass<=(final err_count==0) -> IDLE.
REQ-021 Latency: start high in cycle N -> done high in cycle N+2*DEPTH+3 (N+35 at defaults); busy high during cycles N+1..N+2*DEPTH+3.
REQ-022 err_count range 0..DEPTH; it cannot overflow.
REQ-023 Host arbitration: host_gnt=host_req & IDLE & ~start (combinational); when granted, ram_addr=host_addr, ram_wren=host_wren, ram_data=host_wdata.
REQ-024 A granted host read (host_wren=0) produces host_rvalid=1 and host_rdata=ram_q one cycle later, even if the FSM has left IDLE in that cycle.
REQ-025 A non-granted host_req is dropped; the host retries, and no request is queued.
REQ-026 ram_wren=0 in IDLE without a granted host write, in LAST, and in DONE.

Reset
REQ-027 reset=1 at a posedge -> state IDLE, idx=0, cmp_addr=0, err_count=0, pass=0, done=0, busy=0, host_rvalid=0; this applies mid-COPY or mid-VERIFY and aborts the operation with no done pulse.
REQ-028 ram_wren and host_gnt are 0 in any cycle where reset=1.

Structure
REQ-029 Shared package holds the state encoding type and the ADDR_W/DATA_W defaults.
REQ-030 Single module with no sub-modules; the RAM and ROM stay external.

Verification
REQ-031 Model ROM with rom_data=rom_addr^4'hA. Pulse start at cycle 0 -> RAM[i]=i^4'hA for i=0..15, done at cycle 35, pass=1, err_count=0.
REQ-032 Force ram_q bit0 inverted at RAM addresses 3 and 9 during VERIFY -> err_count=2, pass=0.
REQ-033 In IDLE, host writes 4'h5 to addr 7, then reads addr 7 -> host_gnt=1 on both requests, host_rvalid is asserted one cycle after the read with host_rdata=4'h5.
REQ-034 Assert start and host_req in the same cycle -> host_gnt=0 and the copy begins; host_req during busy -> host_gnt=0 and the RAM is untouched by the host.
REQ-035 Assert reset at COPY idx=6 -> the next cycle is IDLE with busy=0 and no done pulse; a fresh start then completes with pass=1.
REQ-036 Pulse start again while busy -> ignored, and a single done arrives at N+35.
